// File: rtl/relprime_pkg.sv
// relprime_pkg
//   Shared constants and types for the relatively-prime search engine.
//   WIDTH  : operand / result width
//   M_INIT : first candidate m tried for every request
//   state_t: FSM states of relprime_seq
package relprime_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] M_INIT = WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GCD,
        CHECK,
        NEXT,
        DONE
    } state_t;

endpackage : relprime_pkg

// File: rtl/relprime_seq_gcd_sub_unit.sv
// gcd_sub_unit
//   Subtractive Euclid datapath: one subtraction per clock.
//   Ports:
//     CLK, reset : rising-edge clock, asynchronous active-high reset
//     load       : a <= a_init, b <= b_init
//     step       : subtract the smaller register from the larger one
//     a_init     : value loaded into a (the operand n)
//     b_init     : value loaded into b (the candidate m)
//     eq         : a == b, i.e. a holds gcd(a_init, b_init)
//     result     : current value of a
module gcd_sub_unit
    import relprime_pkg::*;
(
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_init,
    input  logic [WIDTH-1:0] b_init,
    output logic             eq,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values; blocking here would let a and b
    // see each other's freshly updated values within the same edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            a <= '0;
            b <= '0;
        end else if (load) begin
            a <= a_init;
            b <= b_init;
        end else if (step) begin
            // Both stay nonzero: only the strictly larger one is reduced.
            if (a > b) begin
                a <= a - b;
            end else if (b > a) begin
                b <= b - a;
            end
        end
    end

    assign eq     = (a == b);
    assign result = a;

endmodule : gcd_sub_unit

// File: rtl/relprime_seq.sv
// relprime_seq
//   On an accepted start, latches n and returns the smallest m >= 2 with
//   gcd(n, m) = 1, trying candidates m = 2, 3, ... with subtractive Euclid.
//   Ports:
//     CLK            : rising-edge clock
//     reset          : asynchronous active-high reset
//     register_value : operand n, sampled only when a start is accepted
//     start          : request, level-sampled; must go low before re-arming
//     out            : result m, held until the next accepted start
//     done           : one-cycle pulse when out/err become valid
//     busy           : high from accepted start through the done cycle
//     err            : set with done when n = 0 (no answer exists)
module relprime_seq
    import relprime_pkg::*;
(
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] register_value,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy,
    output logic             err
);

    state_t           state;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] m;
    logic             armed;

    logic             gcd_eq;
    logic [WIDTH-1:0] gcd_result;

    gcd_sub_unit u_gcd (
        .CLK    (CLK),
        .reset  (reset),
        .load   (state == LOAD),
        .step   (state == GCD),
        .a_init (n),
        .b_init (m),
        .eq     (gcd_eq),
        .result (gcd_result)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n     <= '0;
            m     <= '0;
            out   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
            armed <= 1'b1;
        end else begin
            done <= 1'b0;

            // Seeing start low anywhere re-arms; acceptance clears it, so
            // a start held across completion cannot retrigger.
            if (!start) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start && armed) begin
                        armed <= 1'b0;
                        n     <= register_value;
                        m     <= M_INIT;
                        busy  <= 1'b1;
                        if (register_value == '0) begin
                            out   <= '0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                LOAD: state <= GCD;

                GCD: begin
                    if (gcd_eq) begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (gcd_result == WIDTH'(1)) begin
                        out   <= m;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= NEXT;
                    end
                end

                // gcd(n, n+1) = 1 stops the search before m can wrap.
                NEXT: begin
                    m     <= m + WIDTH'(1);
                    state <= LOAD;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : relprime_seq

// File: tb/tb_relprime_seq.sv
// tb_relprime_seq
//   Directed bench for relprime_seq. Expected results are queued when a
//   request is driven and compared when done pulses; latency comes from a
//   cycle model of the search.
module tb_relprime_seq;
    import relprime_pkg::*;

    localparam int BUDGET = 50000;

    logic             CLK;
    logic             reset;
    logic [WIDTH-1:0] register_value;
    logic             start;
    logic [WIDTH-1:0] out;
    logic             done;
    logic             busy;
    logic             err;

    relprime_seq dut (
        .CLK            (CLK),
        .reset          (reset),
        .register_value (register_value),
        .start          (start),
        .out            (out),
        .done           (done),
        .busy           (busy),
        .err            (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             err;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles from acceptance edge to the cycle in which done is high:
    // per candidate LOAD + subtractions + equality cycle + CHECK (+ NEXT),
    // then the DONE cycle itself.
    function automatic int model_latency(input logic [WIDTH-1:0] nv);
        int x, y, mm, lat;
        if (nv == '0) return 1;
        lat = 0;
        mm  = 2;
        while (mm < 70000) begin
            x = int'(nv);
            y = mm;
            lat++;
            while (x != y) begin
                if (x > y) x = x - y;
                else       y = y - x;
                lat++;
            end
            lat += 2;
            if (x == 1) return lat + 1;
            lat++;
            mm++;
        end
        return -1;
    endfunction

    // Drives one request at a negedge, holds start for 'hold' cycles,
    // scrambles register_value while busy, and checks the result on done.
    task automatic run_req(input string tag, input logic [WIDTH-1:0] nv, input int hold,
                           input logic [WIDTH-1:0] exp_out, input logic exp_err);
        exp_t e;
        int   cyc;
        bit   got;
        sb.push_back('{out: exp_out, err: exp_err, lat: model_latency(nv)});
        register_value = nv;
        start          = 1'b1;
        cyc            = 0;
        got            = 1'b0;
        while (!got && cyc < BUDGET) begin
            @(negedge CLK);
            cyc++;
            register_value = WIDTH'($urandom);
            if (cyc >= hold) start = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, 32'(got), 32'(1));
        if (got) begin
            check({tag, "_out"},     32'(out),  32'(e.out));
            check({tag, "_err"},     32'(err),  32'(e.err));
            check({tag, "_latency"}, 32'(cyc),  32'(e.lat));
            check({tag, "_busy_at_done"}, 32'(busy), 32'(1));
            @(negedge CLK);
            if (cyc + 1 >= hold) start = 1'b0;
            check({tag, "_done_single"}, 32'(done), 32'(0));
            check({tag, "_busy_after"},  32'(busy), 32'(0));
            check({tag, "_out_held"},    32'(out),  32'(e.out));
        end
    endtask

    initial begin
        int dones;
        reset          = 1'b1;
        start          = 1'b0;
        register_value = '0;
        repeat (2) @(negedge CLK);
        check("reset_out",  32'(out),  32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_err",  32'(err),  32'(0));
        reset = 1'b0;
        @(negedge CLK);

        // 5432 = 2^3 * 7 * 97, start held for two cycles
        run_req("n5432", 16'd5432, 2, 16'd3, 1'b0);
        repeat (3) @(negedge CLK);
        check("n5432_no_extra_done", 32'(done), 32'(0));

        // back-to-back requests with start toggled low between them
        run_req("n30", 16'd30, 1, 16'd7, 1'b0);
        @(negedge CLK);
        run_req("n1",  16'd1,  1, 16'd2, 1'b0);
        @(negedge CLK);
        run_req("n2",  16'd2,  1, 16'd3, 1'b0);
        @(negedge CLK);

        // n = 0: done the cycle after acceptance, error flagged
        run_req("n0", 16'd0, 1, 16'd0, 1'b1);
        @(negedge CLK);

        // start held through completion must not retrigger
        run_req("held", 16'd9, 1000000, 16'd2, 1'b0);
        dones = 0;
        repeat (20) begin
            @(negedge CLK);
            if (done === 1'b1) dones++;
        end
        check("held_no_retrigger_done", 32'(dones), 32'(0));
        check("held_no_retrigger_busy", 32'(busy),  32'(0));
        start = 1'b0;
        @(negedge CLK);
        run_req("rearm", 16'd10, 1, 16'd3, 1'b0);
        @(negedge CLK);

        // reset in the middle of the GCD phase: immediate clear, no done
        register_value = 16'd5432;
        start          = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (6) @(negedge CLK);
        check("midrst_busy_before", 32'(busy), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("midrst_out",  32'(out),  32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_err",  32'(err),  32'(0));
        @(negedge CLK);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done === 1'b1) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'(0));
        run_req("after_rst", 16'd5432, 1, 16'd3, 1'b0);
        @(negedge CLK);

        // largest operand; register_value is scrambled while busy
        run_req("nFFFF", 16'hFFFF, 1, 16'd2, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_relprime_seq

// File: doc/relprime_seq.md
# relprime_seq

Sequential relatively-prime search engine: on a start request it latches a 16-bit operand n and returns the smallest m ≥ 2 with gcd(n, m) = 1. It uses subtractive Euclid, one subtract per clock, and signals completion with a done pulse and a held result. It is the responder end of the start/out handshake that the top-level relprime benches drive. It replaces the free-running datapath with an explicit busy/done protocol.

## Interface
- WIDTH, 16, operand/result width
- M_INIT, 2, first candidate m
- CLK  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- register_value  in  WIDTH  operand n, sampled only on accepted start
- start  in  1  request, level-sampled
- out  out  WIDTH  result m; held until next accepted start
- done  out  1  one-cycle pulse when out becomes valid
- busy  out  1  high from accepted start until the done cycle, inclusive
- err  out  1  high with done when n = 0 (no answer exists); held with out

## Operation
- States: IDLE, LOAD, GCD, CHECK, NEXT, DONE (enum in package).
- IDLE:
  - start=1 → latch n ← register_value and m ← M_INIT, go to LOAD; busy rises next cycle.
  - If register_value = 0, go directly to DONE with out=0, err=1.
- LOAD: a ← n, b ← m. Go to GCD.
- GCD, one action per cycle:
  - a > b → a ← a − b.
  - b > a → b ← b − a.
  - a = b → go to CHECK.
- CHECK:
  - a = 1 → out ← m, err ← 0, go to DONE.
  - Otherwise go to NEXT.
- NEXT: m ← m + 1, go to LOAD. m cannot wrap: gcd(n, n+1) = 1 terminates before m exceeds n+1. For n = 0xFFFF, m = 2 succeeds.
- DONE: done=1 for this cycle. Return to IDLE.
- Re-arm: IDLE accepts a new start only after start has been observed low at least once since the previous acceptance. A start held high across completion does not retrigger.
- start during LOAD/GCD/CHECK/NEXT/DONE: ignored. register_value changes during busy: ignored.
- Arithmetic: unsigned WIDTH-bit. a and b never reach 0 because both are nonzero at LOAD.

## Timing
- Reset (async assert, sync deassert at the next CLK edge): state=IDLE, out=0, done=0, busy=0, err=0, a=b=m=0, re-arm flag set.
- Start accepted at edge k → LOAD at k+1. Each candidate costs 1 (LOAD) + g (GCD cycles, including the equality cycle) + 1 (CHECK), plus 1 (NEXT) if it fails.
- done asserts in the cycle after the CHECK success. out, err and done update on the same edge.
- n=1 case: LOAD, GCD(a=b=1? no: a=1,b=2 → b←1), GCD(eq), CHECK, DONE → done 5 cycles after acceptance.
- n=0 case: done the cycle after acceptance.
- Reset mid-operation: immediate abort to the reset values; no done pulse.

## Structure
- relprime_pkg: WIDTH, M_INIT, state_t enum.
- Sub-module gcd_sub_unit: a/b registers, load, step, eq flag, result a.
- relprime_seq contains the FSM, the m counter, the re-arm flag and the output registers.

## Test plan
- register_value=5432 (2³·7·97), start high 2 cycles → out=3, err=0, single done pulse, busy low afterwards.
- register_value=30, then 1, then 2 in back-to-back requests (start toggled low between) → out=7, 2, 3 respectively.
- register_value=0 → done at acceptance+1, out=0, err=1.
- start held high through completion → exactly one done. No new request until start drops and rises again.
- Reset asserted mid-GCD for n=5432 → all outputs 0 immediately, no done. A fresh start afterwards yields out=3.
- register_value=0xFFFF → out=2. Change register_value while busy → result unaffected.
